// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: groups the measurement-side signals of one PWM decoder.
// Latency: n/a (wires only).
// Backpressure: none; START is a pulse and results are one-cycle strobes.
// Ports: master drives START/CYCLE/TIME_CNT/PWM_IN and observes the results;
//   slave (the decoder) consumes the stimulus and drives DUTY/PHASE/ERR/BUSY/DOUT_VALID.
interface pwm_decoder_if #(
   parameter int WIDTH = 13
);
   logic             START;
   logic [WIDTH-1:0] CYCLE;
   logic [WIDTH-1:0] TIME_CNT;
   logic             PWM_IN;
   logic [WIDTH-1:0] DUTY;
   logic [WIDTH-1:0] PHASE;
   logic             ERR;
   logic             BUSY;
   logic             DOUT_VALID;

   modport master (
      output START, CYCLE, TIME_CNT, PWM_IN,
      input  DUTY, PHASE, ERR, BUSY, DOUT_VALID
   );

   modport slave (
      input  START, CYCLE, TIME_CNT, PWM_IN,
      output DUTY, PHASE, ERR, BUSY, DOUT_VALID
   );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the (duty, phase) pair of one PWM output over one period.
// Latency: DOUT_VALID 3 CLK after the sample with tcnt_d == T-1.
// Backpressure: none; one-cycle result strobe, outputs hold until next result or RST.
// Ports: CLK, RST (synchronous, active-high); bus (pwm_decoder_if.slave):
//   START, CYCLE, TIME_CNT, PWM_IN in; DUTY, PHASE, ERR, BUSY, DOUT_VALID out.
// Option macro PWM_DECODER_CONTINUOUS_EN: after one START, stream a result every period.
module pwm_decoder #(
   parameter int WIDTH    = 13,
   parameter int IN_DELAY = 1
) (
   input  logic          CLK,
   input  logic          RST,
   pwm_decoder_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_MEASURE, S_CALC1, S_CALC2, S_DONE
   } state_t;

   state_t state, state_nx;

   // TIME_CNT delayed to line up with PWM_IN
   logic [WIDTH-1:0] tcnt_d;
   generate
      if (IN_DELAY == 0) begin : g_nodly
         assign tcnt_d = bus.TIME_CNT;
      end else begin : g_dly
         logic [WIDTH-1:0] sr [IN_DELAY];
         always_ff @(posedge CLK) begin
            if (RST) begin
               for (int i = 0; i < IN_DELAY; i++) sr[i] <= '0;
            end else begin
               sr[0] <= bus.TIME_CNT;
               for (int i = 1; i < IN_DELAY; i++) sr[i] <= sr[i-1];
            end
         end
         assign tcnt_d = sr[IN_DELAY-1];
      end
   endgenerate

   // Measurement state
   logic             prev, first, err, lvl_c;
   logic [WIDTH-1:0] t_len, r, f, t_prev;
   logic [1:0]       rise_cnt, fall_cnt;
   // Snapshot of a finished period, consumed by the two calc stages
   logic             c1_vld, c2_vld, c_err, c_lvl, err_q;
   logic [WIDTH-1:0] c_r, c_f, c_t;
   logic [1:0]       c_rc, c_fc;
   logic [WIDTH:0]   d_q;
   // Outputs
   logic [WIDTH-1:0] duty_q, phase_q;
   logic             err_o, vld_o;

   logic             is_last, rise, fall, err_nx;
   logic [WIDTH-1:0] r_nx, f_nx;
   logic [1:0]       rc_nx, fc_nx;
   logic [WIDTH:0]   d_calc, s_calc;
   logic [WIDTH-1:0] p_calc;

   assign is_last = (tcnt_d == t_len - 1'b1);
   assign rise    = bus.PWM_IN & ~prev;
   assign fall    = ~bus.PWM_IN & prev;
   assign lvl_c   = bus.PWM_IN;

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (bus.START) state_nx = S_ARM;
         // prev holds the t=T-1 level when MEASURE sees t=0
         S_ARM:     if (is_last) state_nx = S_MEASURE;
`ifdef PWM_DECODER_CONTINUOUS_EN
         S_MEASURE: state_nx = S_MEASURE;
`else
         S_MEASURE: if (is_last) state_nx = S_CALC1;
`endif
         S_CALC1:   state_nx = S_CALC2;
         S_CALC2:   state_nx = S_DONE;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   // Per-sample edge capture; counts saturate at 2, which already marks an error
   always_comb begin
      r_nx   = r;
      f_nx   = f;
      rc_nx  = rise_cnt;
      fc_nx  = fall_cnt;
      err_nx = err;
      if (rise) begin
         r_nx = tcnt_d;
         if (rise_cnt != 2'd2) rc_nx = rise_cnt + 2'd1;
      end
      if (fall) begin
         f_nx = tcnt_d;
         if (fall_cnt != 2'd2) fc_nx = fall_cnt + 2'd1;
      end
      if (first ? (tcnt_d != '0) : (tcnt_d != t_prev + 1'b1)) err_nx = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         prev     <= 1'b0;
         first    <= 1'b0;
         err      <= 1'b0;
         t_len    <= '0;
         r        <= '0;
         f        <= '0;
         t_prev   <= '0;
         rise_cnt <= '0;
         fall_cnt <= '0;
         c1_vld   <= 1'b0;
         c_err    <= 1'b0;
         c_lvl    <= 1'b0;
         c_r      <= '0;
         c_f      <= '0;
         c_t      <= '0;
         c_rc     <= '0;
         c_fc     <= '0;
      end else begin
         prev   <= bus.PWM_IN;
         c1_vld <= 1'b0;
         if (state == S_IDLE && bus.START) begin
            t_len    <= bus.CYCLE;
            r        <= '0;
            f        <= '0;
            rise_cnt <= '0;
            fall_cnt <= '0;
            err      <= 1'b0;
            first    <= 1'b1;
         end
         if (state == S_MEASURE) begin
            r        <= r_nx;
            f        <= f_nx;
            rise_cnt <= rc_nx;
            fall_cnt <= fc_nx;
            err      <= err_nx;
            first    <= 1'b0;
            t_prev   <= tcnt_d;
            if (is_last) begin
               // hand the finished period to the calc stages so sampling can go on
               c_r    <= r_nx;
               c_f    <= f_nx;
               c_rc   <= rc_nx;
               c_fc   <= fc_nx;
               c_err  <= err_nx;
               c_lvl  <= lvl_c;
               c_t    <= t_len;
               c1_vld <= 1'b1;
`ifdef PWM_DECODER_CONTINUOUS_EN
               // next period starts with the very next sample
               t_len    <= bus.CYCLE;
               r        <= '0;
               f        <= '0;
               rise_cnt <= '0;
               fall_cnt <= '0;
               err      <= 1'b0;
               first    <= 1'b1;
`endif
            end
         end
      end
   end

   // Duty: pulse width, allowing the high interval to wrap through t=0
   always_comb begin
      d_calc = '0;
      if (c_rc == 2'd0)  d_calc = c_lvl ? {1'b0, c_t} : '0;
      else if (c_f >= c_r) d_calc = {1'b0, c_f} - {1'b0, c_r};
      else                 d_calc = {1'b0, c_f} + {1'b0, c_t} - {1'b0, c_r};
   end

   // Phase: undo f = T - phase + ceil(duty/2); s < 2T so one subtract suffices
   always_comb begin
      s_calc = ((d_q + 1'b1) >> 1) + {1'b0, c_t} - {1'b0, c_f};
      p_calc = '0;
      if (c_rc != 2'd0)
         p_calc = WIDTH'((s_calc >= {1'b0, c_t}) ? s_calc - {1'b0, c_t} : s_calc);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         c2_vld  <= 1'b0;
         d_q     <= '0;
         err_q   <= 1'b0;
         duty_q  <= '0;
         phase_q <= '0;
         err_o   <= 1'b0;
         vld_o   <= 1'b0;
      end else begin
         c2_vld <= c1_vld;
         vld_o  <= c2_vld;
         if (c1_vld) begin
            d_q   <= d_calc;
            err_q <= c_err | (c_rc != c_fc) | (c_rc > 2'd1);
         end
         if (c2_vld) begin
            err_o   <= err_q;
            duty_q  <= err_q ? '0 : WIDTH'(d_q);
            phase_q <= err_q ? '0 : p_calc;
         end
      end
   end

   assign bus.DUTY       = duty_q;
   assign bus.PHASE      = phase_q;
   assign bus.ERR        = err_o;
   assign bus.DOUT_VALID = vld_o;
   assign bus.BUSY       = (state != S_IDLE);

endmodule
